seq_1010_pattern_tx: RTL

Serial transmitter for the 1010 detector protocol. It emits the pattern 1010 a programmable number of times, MSB-first, one bit per clock, with a programmable run of 0 gap bits between repetitions. Its output drives the 1010 sequence detectors directly, both overlapping and non-overlapping variants. A gap of 0 produces back-to-back patterns, which is the stimulus that separates overlapping from non-overlapping detection.

---
 rtl/seq_1010_pkg.sv | 26 ++
 rtl/seq_down_counter.sv | 31 +++
 rtl/seq_1010_pattern_tx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/seq_1010_pkg.sv
// Shared definitions for the 1010 pattern transmitter and the 1010 detectors:
// state width, state encoding and a small helper for the Busy decode.
package seq_1010_pkg;

   localparam int STATE_W = 3;

   // Encoding matches the detector blocks; codes 7 and above are unused.
   typedef enum logic [STATE_W-1:0] {
      IDLE  = 3'd0,
      S1    = 3'd1,
      S10   = 3'd2,
      S101  = 3'd3,
      S1010 = 3'd4,
      GAP   = 3'd5,
      DONE  = 3'd6
   } state_t;

   // A stream is in flight in every state except IDLE and DONE.
   function automatic logic is_busy(input state_t s);
      case (s)
         S1, S10, S101, S1010, GAP: is_busy = 1'b1;
         default:                   is_busy = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter with a zero flag. Load wins over decrement, and the
// count holds at zero instead of wrapping.
module seq_down_counter #(
   parameter int W = 4
) (
   input  logic         Clk,
   input  logic         Rst,
   input  logic         Load,
   input  logic [W-1:0] Load_Val,
   input  logic         Dec,
   output logic [W-1:0] Cnt,
   output logic         Zero
);

   logic [W-1:0] cnt_reg;

   // Count register: clear on reset, load on request, otherwise step down.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         cnt_reg <= '0;
      end else if (Load) begin
         cnt_reg <= Load_Val;
      end else if (Dec && (cnt_reg != '0)) begin
         cnt_reg <= cnt_reg - W'(1);
      end
   end

   assign Cnt  = cnt_reg;
   assign Zero = (cnt_reg == '0);

endmodule

// File: rtl/seq_1010_pattern_tx.sv
// Serial 1010 pattern transmitter. Emits Count repetitions of 1010, MSB
// first, with Gap zero bits between repetitions, then pulses Done.
module seq_1010_pattern_tx
   import seq_1010_pkg::*;
#(
   parameter int CNT_W = 4,
   parameter int GAP_W = 3
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               Start,
   input  logic               Abort,
   input  logic [CNT_W-1:0]   Count,
   input  logic [GAP_W-1:0]   Gap,
   output logic               Out,
   output logic               Out_Vld,
   output logic               Busy,
   output logic               Done,
   output logic [STATE_W-1:0] cs,
   output logic [STATE_W-1:0] ns
);

   state_t             cs_reg;
   state_t             ns_next;
   logic [GAP_W-1:0]   gap_len_reg;

   logic               accept;
   logic               rep_dec;
   logic               gap_load;
   logic               gap_dec;
   logic [GAP_W-1:0]   gap_load_val;

   logic [CNT_W-1:0]   rep_cnt;
   logic               rep_zero;
   logic [GAP_W-1:0]   gap_cnt;
   logic               gap_zero;
   logic               busy_now;

   assign busy_now     = is_busy(cs_reg);
   // The gap counter counts down to zero inclusive, so it starts one short.
   assign gap_load_val = gap_len_reg - GAP_W'(1);

   // Remaining repetitions, including the one currently being sent.
   seq_down_counter #(
      .W (CNT_W)
   ) u_rep_cnt (
      .Clk      (Clk),
      .Rst      (Rst),
      .Load     (accept),
      .Load_Val (Count),
      .Dec      (rep_dec),
      .Cnt      (rep_cnt),
      .Zero     (rep_zero)
   );

   // Remaining gap bit times after the current one.
   seq_down_counter #(
      .W (GAP_W)
   ) u_gap_cnt (
      .Clk      (Clk),
      .Rst      (Rst),
      .Load     (gap_load),
      .Load_Val (gap_load_val),
      .Dec      (gap_dec),
      .Cnt      (gap_cnt),
      .Zero     (gap_zero)
   );

   // State register.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         cs_reg <= IDLE;
      end else begin
         cs_reg <= ns_next;
      end
   end

   // Gap length is captured only when a Start is accepted.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         gap_len_reg <= '0;
      end else if (accept) begin
         gap_len_reg <= Gap;
      end
   end

   // Next-state logic and counter controls; Abort overrides everything.
   always_comb begin
      ns_next  = cs_reg;
      accept   = 1'b0;
      rep_dec  = 1'b0;
      gap_load = 1'b0;
      gap_dec  = 1'b0;
      if (busy_now && Abort) begin
         ns_next = IDLE;
      end else begin
         case (cs_reg)
            IDLE: begin
               if (Start && !Abort) begin
                  accept  = 1'b1;
                  ns_next = (Count != '0) ? S1 : DONE;
               end
            end
            S1:    ns_next = S10;
            S10:   ns_next = S101;
            S101:  ns_next = S1010;
            S1010: begin
               // Last repetition (zero cannot occur here, treated the same).
               if (rep_zero || (rep_cnt == CNT_W'(1))) begin
                  ns_next = DONE;
               end else begin
                  rep_dec = 1'b1;
                  if (gap_len_reg == '0) begin
                     ns_next = S1;
                  end else begin
                     ns_next  = GAP;
                     gap_load = 1'b1;
                  end
                  end
            end
            GAP: begin
               if (gap_zero) begin
                  ns_next = S1;
               end else begin
                  gap_dec = (gap_cnt != '0);
               end
            end
            DONE:    ns_next = IDLE;
            default: ns_next = IDLE;
         endcase
      end
   end

   // Moore output decode from the current state.
   always_comb begin
      Out     = 1'b0;
      Out_Vld = 1'b0;
      Done    = 1'b0;
      case (cs_reg)
         S1, S101: begin
            Out     = 1'b1;
            Out_Vld = 1'b1;
         end
         S10, S1010, GAP: begin
            Out_Vld = 1'b1;
         end
         DONE:    Done = 1'b1;
         default: ;
      endcase
   end

   assign Busy = busy_now;
   assign cs   = cs_reg;
   assign ns   = ns_next;

endmodule
